// File: rtl/neuron_pkg.sv
// Shared types and helpers for the spiking-neuron family: state encoding,
// default widths and a width-generic saturating adder.
package neuron_pkg;

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } neuron_state_e;

  localparam int DATA_W    = 8;
  localparam int POT_W_DEF = 12;
  localparam int COUNT_W   = 8;

  // Operands are zero-extended into 32 bits; the result clamps at 2^width-1.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] full;
    logic [31:0] max_val;
    full    = {1'b0, a} + {1'b0, b};
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (full > {1'b0, max_val}) ? max_val : full[31:0];
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: saturating accumulate, floored leak,
// threshold compare, one-cycle spike and a fixed-length refractory window.
module lif_neuron
  import neuron_pkg::*;
#(
  parameter int POT_W          = POT_W_DEF,
  parameter int REFRACT_CYCLES = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               valid_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic [POT_W-1:0]   threshold_i,
  input  logic [DATA_W-1:0]  leak_i,
  output logic               spike_o,
  output logic [POT_W-1:0]   potential_o,
  output logic               refractory_o,
  output logic [COUNT_W-1:0] spike_count_o
);

  localparam int CNT_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

  neuron_state_e      state_q;
  logic [CNT_W-1:0]   refr_cnt_q;
  logic [POT_W-1:0]   pot_q;
  logic               spike_q;
  logic [COUNT_W-1:0] count_q;

  logic [POT_W-1:0] add_val;
  logic [POT_W-1:0] leak_ext;
  logic [POT_W-1:0] sum;
  logic [POT_W-1:0] next_pot;
  logic             fire;

  // Addition saturates first, then the leak is removed with a floor at zero.
  always_comb begin
    add_val  = valid_i ? POT_W'(data_i) : '0;
    leak_ext = POT_W'(leak_i);
    sum      = POT_W'(sat_add(32'(pot_q), 32'(add_val), POT_W));
    next_pot = (sum > leak_ext) ? (sum - leak_ext) : '0;
    fire     = (next_pot >= threshold_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= INTEGRATE;
      refr_cnt_q <= '0;
      pot_q      <= '0;
      spike_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      spike_q <= 1'b0;
      if (en_i) begin
        case (state_q)
          INTEGRATE: begin
            if (fire) begin
              pot_q   <= '0;
              spike_q <= 1'b1;
              count_q <= count_q + COUNT_W'(1);
              if (REFRACT_CYCLES > 0) begin
                state_q    <= REFRACTORY;
                refr_cnt_q <= CNT_W'(REFRACT_CYCLES);
              end
            end else begin
              pot_q <= next_pot;
            end
          end
          REFRACTORY: begin
            pot_q      <= '0;
            refr_cnt_q <= refr_cnt_q - CNT_W'(1);
            if (refr_cnt_q == CNT_W'(1)) begin
              state_q <= INTEGRATE;
            end
          end
          default: state_q <= INTEGRATE;
        endcase
      end
    end
  end

  assign spike_o       = spike_q;
  assign potential_o   = pot_q;
  assign refractory_o  = (state_q == REFRACTORY);
  assign spike_count_o = count_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Scoreboarded bench for lif_neuron: directed scenarios plus random traffic,
// checked against an arithmetic reference model of the neuron.
module tb_lif_neuron;

  localparam int POT_W   = 12;
  localparam int REFRACT = 3;
  localparam int POT_MAX = (1 << POT_W) - 1;

  logic             clk_i;
  logic             rst_ni;
  logic             en_i;
  logic             valid_i;
  logic [7:0]       data_i;
  logic [POT_W-1:0] threshold_i;
  logic [7:0]       leak_i;
  logic             spike_o;
  logic [POT_W-1:0] potential_o;
  logic             refractory_o;
  logic [7:0]       spike_count_o;

  lif_neuron #(.POT_W(POT_W), .REFRACT_CYCLES(REFRACT)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .threshold_i  (threshold_i),
    .leak_i       (leak_i),
    .spike_o      (spike_o),
    .potential_o  (potential_o),
    .refractory_o (refractory_o),
    .spike_count_o(spike_count_o)
  );

  typedef struct {
    int spike;
    int pot;
    int refr;
    int cnt;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  int m_pot = 0;
  int m_refr_left = 0;
  int m_count = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic compare(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compare("spike_o", int'(spike_o), e.spike);
    compare("potential_o", int'(potential_o), e.pot);
    compare("refractory_o", int'(refractory_o), e.refr);
    compare("spike_count_o", int'(spike_count_o), e.cnt);
  endtask

  // Monitor: every registered output update is popped and checked just after the edge.
  always @(posedge clk_i) begin
    #1;
    if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
  end

  task automatic applyStimulus(input bit en, input bit valid, input int data,
                               input int thr, input int leak);
    exp_t e;
    int   sum;
    int   nxt;
    int   spk;
    @(negedge clk_i);
    en_i        = en;
    valid_i     = valid;
    data_i      = 8'(data);
    threshold_i = POT_W'(thr);
    leak_i      = 8'(leak);
    spk = 0;
    if (en) begin
      if (m_refr_left > 0) begin
        m_refr_left--;
        m_pot = 0;
      end else begin
        sum = m_pot + (valid ? data : 0);
        if (sum > POT_MAX) sum = POT_MAX;
        nxt = sum - leak;
        if (nxt < 0) nxt = 0;
        if (nxt >= thr) begin
          spk = 1;
          m_pot = 0;
          m_count = (m_count + 1) % 256;
          m_refr_left = REFRACT;
        end else begin
          m_pot = nxt;
        end
      end
    end
    e.spike = spk;
    e.pot   = m_pot;
    e.refr  = (m_refr_left > 0) ? 1 : 0;
    e.cnt   = m_count;
    sb_q.push_back(e);
  endtask

  // Reset lands mid-cycle; outputs must clear before any further clock edge.
  task automatic doReset();
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    compare("reset spike_o", int'(spike_o), 0);
    compare("reset potential_o", int'(potential_o), 0);
    compare("reset refractory_o", int'(refractory_o), 0);
    compare("reset spike_count_o", int'(spike_count_o), 0);
    m_pot = 0;
    m_refr_left = 0;
    m_count = 0;
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni      = 1'b1;
    en_i        = 1'b0;
    valid_i     = 1'b0;
    data_i      = '0;
    threshold_i = '0;
    leak_i      = '0;
    doReset();

    // Basic firing then refractory, then one more integrate
    repeat (8) applyStimulus(1, 1, 30, 100, 0);

    // Leak floor keeps potential at zero
    doReset();
    repeat (10) applyStimulus(1, 1, 5, 100, 10);

    // Saturation: 16 inputs reach 4080, the 17th clamps and fires
    doReset();
    repeat (20) applyStimulus(1, 1, 255, 4095, 0);

    // Enable gating mid-integration
    doReset();
    repeat (2) applyStimulus(1, 1, 40, 500, 0);
    repeat (5) applyStimulus(0, 1, 200, 0, 0);
    repeat (3) applyStimulus(1, 1, 40, 500, 0);

    // Threshold zero fires every fourth enabled cycle; long run wraps the count
    doReset();
    repeat (1040) applyStimulus(1, 0, 0, 0, 0);

    // Reset in the middle of a refractory window
    doReset();
    repeat (5) applyStimulus(1, 1, 30, 100, 0);
    doReset();
    repeat (3) applyStimulus(1, 1, 30, 100, 0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      int thr;
      thr = ($urandom_range(0, 15) == 0) ? POT_MAX : int'($urandom_range(0, 1500));
      if ($urandom_range(0, 400) == 0) doReset();
      applyStimulus(($urandom_range(0, 7) != 0), $urandom_range(0, 1),
                    int'($urandom_range(0, 255)), thr, int'($urandom_range(0, 40)));
    end

    repeat (3) @(posedge clk_i);
    #2;
    compare("scoreboard drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lif_neuron.md
# lif_neuron

Leaky integrate-and-fire neuron that receives the truncated 8-bit weighted products produced by the synapse stage and turns them into output spikes. The block accumulates weighted input into a saturating membrane potential, applies a per-timestep leak, and compares the result against a runtime threshold. On a threshold crossing it emits a one-cycle spike, resets the potential, and enters a programmable refractory period. It is the downstream consumer of synapse outputs and the producer of spike events for the next layer.

## Interface
- `POT_W`, default 12: membrane potential width in bits, ≥ 9.
- `REFRACT_CYCLES`, default 3: refractory length in enabled cycles; 0 disables the refractory period.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `en_i` in 1: timestep enable; state advances only when high.
- `valid_i` in 1: `data_i` qualifier.
- `data_i` in 8: unsigned weighted input from a synapse.
- `threshold_i` in POT_W: firing threshold, unsigned.
- `leak_i` in 8: unsigned amount subtracted per enabled cycle.
- `spike_o` out 1: one-cycle spike pulse.
- `potential_o` out POT_W: registered membrane potential.
- `refractory_o` out 1: high while in REFRACTORY.
- `spike_count_o` out 8: total spikes fired; wraps 255→0.

## Operation
- States: INTEGRATE and REFRACTORY. Reset enters INTEGRATE.
- On reset, all outputs are 0 and the refractory counter is 0.
- When `en_i` is low, all state, potential, counter and spike count hold, and `spike_o` is 0.
- In INTEGRATE with `en_i` high:
  - `sum = pot + (valid_i ? data_i : 0)`, saturating at 2^POT_W−1.
  - `next = sum − leak_i`, floored at 0.
  - Addition happens before leak.
- Fire condition: `next >= threshold_i`, compared unsigned. Consequence: `threshold_i == 0` fires on every enabled INTEGRATE cycle.
- On fire, at the next edge:
  - `pot` ← 0.
  - `spike_o` ← 1.
  - `spike_count_o` increments.
  - If REFRACT_CYCLES > 0: go to REFRACTORY and load the counter with REFRACT_CYCLES.
  - Otherwise: stay in INTEGRATE.
- Without fire: `pot` ← `next`.
- In REFRACTORY with `en_i` high:
  - `valid_i`/`data_i` are ignored; `pot` stays 0; no leak applies.
  - The counter decrements.
  - When the counter goes 1→0, the state returns to INTEGRATE.
  - Refractory therefore consumes exactly REFRACT_CYCLES enabled cycles.
- `refractory_o` is high exactly while state is REFRACTORY.
- Values of `threshold_i`/`leak_i` are sampled every enabled cycle; changing them mid-operation takes effect on the next enabled cycle.
- Saturation is not an error: a potential pinned at max still fires if `threshold_i` ≤ max.

## Timing
- All outputs are registered.
- Latency is 1 cycle: for the enabled cycle N whose `next` crosses threshold:
  - `spike_o` = 1 and `potential_o` = 0 in cycle N+1.
  - `refractory_o` = 1 from cycle N+1 (when REFRACT_CYCLES > 0).
- `spike_o` is never high two consecutive cycles when REFRACT_CYCLES > 0. With REFRACT_CYCLES = 0 it may stay high on back-to-back enabled cycles.
- The first INTEGRATE cycle after refractory is enabled cycle N+1+REFRACT_CYCLES.
- Reset asserted mid-refractory or mid-integration clears everything immediately (asynchronously); the first post-reset enabled cycle integrates normally.

## Structure
- Package `neuron_pkg` holds:
  - the state enum (INTEGRATE, REFRACTORY);
  - default width constants (data width 8, POT_W 12, count width 8);
  - a saturating-add helper function, reused by future multi-input neuron variants.
- No sub-module is required. Datapath (saturating add, floored leak, compare) and FSM/counter live in one module.
- The refractory counter width is $clog2(REFRACT_CYCLES+1), minimum 1.

## Test plan
All scenarios use POT_W=12, REFRACT_CYCLES=3.
- **Reset values:** assert `rst_ni` low asynchronously mid-clock → `spike_o`, `potential_o`, `refractory_o`, `spike_count_o` all 0 immediately.
- **Basic firing and refractory:**
  - Stimulus: threshold 100, leak 0, `data_i` 30, `valid_i` and `en_i` high continuously.
  - `potential_o` reads 30, 60, 90; `spike_o` pulses with `potential_o` 0 and count 1.
  - `refractory_o` is high 3 cycles with inputs ignored; the next potential is 30.
- **Leak floor:** threshold 100, leak 10, `data_i` 5 every cycle → `potential_o` stays 0 and no spike.
- **Saturation:** threshold 4095, leak 0, `data_i` 255 → potential 4080 after 16 inputs; the 17th saturates at 4095 and fires.
- **Enable gating and threshold-0 firing:**
  - Drop `en_i` for 5 cycles mid-integration → potential, state and count hold; `spike_o` is 0.
  - Set threshold 0, REFRACT_CYCLES 3 → spikes every 4th enabled cycle.
- **Counter wrap and reset mid-refractory:**
  - Fire 256 times → `spike_count_o` wraps to 0.
  - Assert reset during REFRACTORY → `refractory_o` drops immediately; after release the first enabled cycle integrates `data_i`.
